// File: rtl/neuron_integrator_seq.sv
// Sequential neuron integrator: streams axon beats for one neuron, accumulates
// type-selected weights, applies leak, fires against threshold and applies the reset mode.
module neuron_integrator_seq #(
   parameter int NUM_AXONS       = 256,
   parameter int LEAK_WIDTH      = 9,
   parameter int WEIGHT_WIDTH    = 9,
   parameter int THRESHOLD_WIDTH = 9,
   parameter int POTENTIAL_WIDTH = 9,
   parameter int NUM_WEIGHTS     = 4,
   parameter int NUM_RESET_MODES = 2,
   localparam int TYPE_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1,
   localparam int MODE_W = (NUM_RESET_MODES > 1) ? $clog2(NUM_RESET_MODES) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  start_i,
   input  logic signed [POTENTIAL_WIDTH-1:0]     potential_i,
   input  logic signed [LEAK_WIDTH-1:0]          leak_i,
   input  logic        [THRESHOLD_WIDTH-1:0]     threshold_i,
   input  logic        [MODE_W-1:0]              reset_mode_i,
   input  logic        [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights_i,
   input  logic                                  axon_valid_i,
   output logic                                  axon_ready_o,
   input  logic                                  axon_in_i,
   input  logic                                  synapses_in_i,
   input  logic        [TYPE_W-1:0]              axon_type_i,
   input  logic                                  axon_last_i,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  spike_o,
   output logic signed [POTENTIAL_WIDTH-1:0]     potential_o
);

   localparam int CNT_W  = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
   localparam int MAX_AW = (WEIGHT_WIDTH > LEAK_WIDTH) ? WEIGHT_WIDTH : LEAK_WIDTH;
   localparam int MAX_BW = (POTENTIAL_WIDTH > THRESHOLD_WIDTH + 1) ? POTENTIAL_WIDTH : THRESHOLD_WIDTH + 1;
   localparam int SUM_W  = ((MAX_AW > MAX_BW) ? MAX_AW : MAX_BW) + 1;

   localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((2 ** (POTENTIAL_WIDTH - 1)) - 1);
   localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(-(2 ** (POTENTIAL_WIDTH - 1)));

   typedef enum logic [2:0] {S_IDLE, S_INTEG, S_LEAK, S_FIRE, S_DONE} state_t;

   state_t state, state_next;

   logic signed [POTENTIAL_WIDTH-1:0]       acc;
   logic signed [LEAK_WIDTH-1:0]            leak_q;
   logic        [THRESHOLD_WIDTH-1:0]       thr_q;
   logic        [MODE_W-1:0]                mode_q;
   logic        [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights_q;
   logic        [CNT_W-1:0]                 cnt;
   logic                                    fire_q;

   logic signed [WEIGHT_WIDTH-1:0] weight_sel;
   logic signed [SUM_W-1:0]        acc_ext, thr_ext, integ_sum, leak_sum, sub_sum;
   logic                           beat_accept, beat_end, fire;

   function automatic logic signed [POTENTIAL_WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
      if (v > MAX_S)
         return {1'b0, {(POTENTIAL_WIDTH-1){1'b1}}};
      else if (v < MIN_S)
         return {1'b1, {(POTENTIAL_WIDTH-1){1'b0}}};
      else
         return v[POTENTIAL_WIDTH-1:0];
   endfunction

   // Types with no matching weight slot select zero.
   always_comb begin
      weight_sel = '0;
      for (int k = 0; k < NUM_WEIGHTS; k++) begin
         if (axon_type_i == TYPE_W'(k))
            weight_sel = weights_q[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   always_comb begin
      acc_ext     = SUM_W'(acc);
      thr_ext     = $signed(SUM_W'(thr_q));
      integ_sum   = acc_ext + SUM_W'(weight_sel);
      leak_sum    = acc_ext + SUM_W'(leak_q);
      sub_sum     = acc_ext - thr_ext;
      fire        = (acc_ext >= thr_ext);
      beat_accept = (state == S_INTEG) && axon_valid_i;
      beat_end    = beat_accept && (axon_last_i || (cnt == CNT_W'(NUM_AXONS - 1)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next   = state;
      busy_o       = 1'b1;
      axon_ready_o = 1'b0;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i)
               state_next = S_INTEG;
         end
         S_INTEG: begin
            axon_ready_o = 1'b1;
            if (beat_end)
               state_next = S_LEAK;
         end
         S_LEAK:  state_next = S_FIRE;
         S_FIRE:  state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: begin
            busy_o     = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

   // Result registers update while in DONE, so the strobe lands one cycle later.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc         <= '0;
         leak_q      <= '0;
         thr_q       <= '0;
         mode_q      <= '0;
         weights_q   <= '0;
         cnt         <= '0;
         fire_q      <= 1'b0;
         done_o      <= 1'b0;
         spike_o     <= 1'b0;
         potential_o <= '0;
      end else begin
         done_o  <= 1'b0;
         spike_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  acc       <= potential_i;
                  leak_q    <= leak_i;
                  thr_q     <= threshold_i;
                  mode_q    <= reset_mode_i;
                  weights_q <= weights_i;
                  cnt       <= '0;
               end
            end
            S_INTEG: begin
               if (beat_accept) begin
                  cnt <= cnt + CNT_W'(1);
                  if (axon_in_i && synapses_in_i)
                     acc <= sat(integ_sum);
               end
            end
            S_LEAK: acc <= sat(leak_sum);
            S_FIRE: begin
               fire_q <= fire;
               if (fire)
                  acc <= (mode_q == MODE_W'(1)) ? sat(sub_sum) : '0;
            end
            S_DONE: begin
               done_o      <= 1'b1;
               spike_o     <= fire_q;
               potential_o <= acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/neuron_integrator_seq.md
Name: neuron_integrator_seq

Overview:
- Sequential successor of the combinational per-axon integrator.
- Processes one neuron per job: streams up to NUM_AXONS axon beats, accumulates the type-selected signed weight for each active axon/synapse pair, applies leak, compares against threshold, emits a spike, and applies the selected reset mode.
- Sits between the core's axon/synapse scheduler (beat source) and the neuron state memory / spike router (result sink).

Parameters:
- NUM_AXONS, 256, max beats per job; axon counter width = $clog2(NUM_AXONS).
- LEAK_WIDTH, 9, signed leak value width.
- WEIGHT_WIDTH, 9, signed weight width.
- THRESHOLD_WIDTH, 9, unsigned threshold width.
- POTENTIAL_WIDTH, 9, signed membrane potential width.
- NUM_WEIGHTS, 4, weights per neuron; TYPE_W = $clog2(NUM_WEIGHTS).
- NUM_RESET_MODES, 2, supported reset modes; MODE_W = $clog2(NUM_RESET_MODES).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  job start, accepted only when busy_o=0.
- potential_i  in  POTENTIAL_WIDTH  signed initial potential, sampled at start.
- leak_i  in  LEAK_WIDTH  signed leak, sampled at start.
- threshold_i  in  THRESHOLD_WIDTH  unsigned threshold, sampled at start.
- reset_mode_i  in  MODE_W  0=hard reset to 0, 1=subtract threshold; sampled at start.
- weights_i  in  NUM_WEIGHTS*WEIGHT_WIDTH  packed signed weights, index k at bits [k*W+:W]; sampled at start.
- axon_valid_i  in  1  beat valid.
- axon_ready_o  out  1  beat ready.
- axon_in_i  in  1  axon spike for this beat.
- synapses_in_i  in  1  synapse connection bit for this beat.
- axon_type_i  in  TYPE_W  weight index for this beat.
- axon_last_i  in  1  final beat of the job.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle result strobe.
- spike_o  out  1  fire result, valid with done_o.
- potential_o  out  POTENTIAL_WIDTH  signed final potential after reset, held until next done_o.

Behaviour:
- Single clock clk_i; reset rst_i is synchronous and active-high. On rst_i: state IDLE, all outputs 0, captured registers 0, axon counter 0. Reset mid-job aborts the job with no done_o.
- States: IDLE -> INTEG -> LEAK -> FIRE -> DONE -> IDLE.
- IDLE: busy_o=0, axon_ready_o=0. start_i=1 captures all job inputs, loads acc=potential_i, counter=0, and moves to INTEG.
- INTEG: busy_o=1, axon_ready_o=1. A beat is accepted when valid&ready.
  - If axon_in_i&synapses_in_i, acc <= sat(acc + weight[axon_type_i]); otherwise acc is unchanged.
  - Leave INTEG after a beat with axon_last_i=1, or after the NUM_AXONS-th accepted beat (counter==NUM_AXONS-1), whichever comes first.
  - Out-of-range axon_type_i (>=NUM_WEIGHTS) contributes 0.
- LEAK (1 cycle): acc <= sat(acc + sign-extended leak).
- FIRE (1 cycle):
  - Compare acc against the zero-extended threshold, evaluated signed at POTENTIAL_WIDTH+1 bits. Fire if acc >= threshold.
  - On fire: mode 0 sets acc=0; mode 1 sets acc=sat(acc-threshold). Unknown mode behaves as mode 0.
  - No fire: acc unchanged.
- DONE (1 cycle): done_o=1; spike_o and potential_o are updated this cycle. spike_o returns to 0 the next cycle. potential_o holds.
- Latency: last beat accepted at edge t gives done_o high in the cycle after edge t+3. Minimum job of 1 beat: start at edge s, done_o high during the cycle following edge s+4.
- busy_o=1 in INTEG, LEAK, FIRE, DONE. start_i while busy is ignored. A start_i sampled in the DONE cycle is also ignored.
- Saturation (sat): clamp to [-2^(POTENTIAL_WIDTH-1), 2^(POTENTIAL_WIDTH-1)-1]. Sums are computed at max(widths)+1 bits before clamping.
- Beats with axon_valid_i=0 stall the job without limit; no timeout.

Test Plan:
- Basic fire, mode 0: potential=0, weights={10,20,-5,1}, threshold=25, leak=0. Send 3 active beats of types 0,1,2, last on the 3rd. Acc=25 -> spike_o=1, potential_o=0, done_o exactly 3 cycles after last beat accepted.
- Subtract mode with leak: potential=100, leak=-10, threshold=50, mode 1, one active beat of weight 5. Acc=95 -> spike_o=1, potential_o=45.
- Saturation: potential=250, weight0=100, 4 active beats, threshold=511 -> potential_o=255, spike_o=0. Repeat with weight -100 from potential=-250 -> potential_o=-256.
- Gating and stalls: beats with axon_in_i=1/synapses_in_i=0 and vice versa, plus valid gaps of 5 cycles. Acc unchanged by gated beats; result matches the active-only sum.
- Auto-terminate: NUM_AXONS=256, 256 beats with no axon_last_i -> exits INTEG after beat 256; axon_ready_o=0 for subsequent beats.
- Reset mid-job: assert rst_i during INTEG after 10 beats -> next cycle busy_o=0, done_o never pulses, potential_o=0. A new job afterwards completes correctly. start_i while busy has no effect.
